// File: rtl/mem_bus_arbiter_if.sv
// Signal bundle between the fetch/LSU requesters, the arbiter and the shared Avalon-style bus.
// The slave modport is the arbiter's view; the master modport is the view of the surrounding logic.
interface mem_bus_arbiter_if;
  logic        i_req;
  logic [31:0] i_addr;
  logic [31:0] i_rdata;
  logic        i_valid;
  logic        d_read;
  logic        d_write;
  logic [31:0] d_addr;
  logic [31:0] d_wdata;
  logic [3:0]  d_byteenable;
  logic [31:0] d_rdata;
  logic        d_valid;
  logic [31:0] address;
  logic        read;
  logic        write;
  logic [31:0] writedata;
  logic [3:0]  byteenable;
  logic [31:0] readdata;
  logic        waitrequest;
  logic        busy;
  logic        timeout_err;

  modport slave (
    input  i_req, i_addr, d_read, d_write, d_addr, d_wdata, d_byteenable,
    input  readdata, waitrequest,
    output i_rdata, i_valid, d_rdata, d_valid,
    output address, read, write, writedata, byteenable, busy, timeout_err
  );

  modport master (
    output i_req, i_addr, d_read, d_write, d_addr, d_wdata, d_byteenable,
    output readdata, waitrequest,
    input  i_rdata, i_valid, d_rdata, d_valid,
    input  address, read, write, writedata, byteenable, busy, timeout_err
  );
endinterface

// File: rtl/mem_bus_arbiter.sv
// Arbitrates the single memory bus between instruction fetch and load/store, one transaction
// in flight; handles waitrequest stalls, the one-cycle read return and a sticky stall timeout.
module mem_bus_arbiter #(
  parameter bit          DATA_PRIORITY = 1'b1,
  parameter int unsigned TIMEOUT       = 0
) (
  input  logic             clk,
  input  logic             reset,
  mem_bus_arbiter_if.slave arb
);

  typedef enum logic [1:0] {IDLE, REQ, RESP, DONE} state_t;

  state_t      state_reg, state_next;
  logic        grant_data_reg, grant_data_next;
  logic        is_write_reg, is_write_next;
  logic        last_data_reg, last_data_next;
  logic [31:0] address_reg, address_next;
  logic        read_reg, read_next;
  logic        write_reg, write_next;
  logic [31:0] writedata_reg, writedata_next;
  logic [3:0]  byteenable_reg, byteenable_next;
  logic [31:0] i_rdata_reg, i_rdata_next;
  logic [31:0] d_rdata_reg, d_rdata_next;
  logic        i_valid_reg, i_valid_next;
  logic        d_valid_reg, d_valid_next;
  logic [15:0] wait_cnt_reg, wait_cnt_next;
  logic        timeout_err_reg, timeout_err_next;

  logic d_any;
  logic pick_data;

  assign d_any = arb.d_read | arb.d_write;
  // On a tie the data port wins outright, or under round-robin when fetch was granted last.
  assign pick_data = d_any & (~arb.i_req | DATA_PRIORITY | ~last_data_reg);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg       <= IDLE;
      grant_data_reg  <= 1'b0;
      is_write_reg    <= 1'b0;
      last_data_reg   <= 1'b1;
      address_reg     <= 32'd0;
      read_reg        <= 1'b0;
      write_reg       <= 1'b0;
      writedata_reg   <= 32'd0;
      byteenable_reg  <= 4'd0;
      i_rdata_reg     <= 32'd0;
      d_rdata_reg     <= 32'd0;
      i_valid_reg     <= 1'b0;
      d_valid_reg     <= 1'b0;
      wait_cnt_reg    <= 16'd0;
      timeout_err_reg <= 1'b0;
    end else begin
      state_reg       <= state_next;
      grant_data_reg  <= grant_data_next;
      is_write_reg    <= is_write_next;
      last_data_reg   <= last_data_next;
      address_reg     <= address_next;
      read_reg        <= read_next;
      write_reg       <= write_next;
      writedata_reg   <= writedata_next;
      byteenable_reg  <= byteenable_next;
      i_rdata_reg     <= i_rdata_next;
      d_rdata_reg     <= d_rdata_next;
      i_valid_reg     <= i_valid_next;
      d_valid_reg     <= d_valid_next;
      wait_cnt_reg    <= wait_cnt_next;
      timeout_err_reg <= timeout_err_next;
    end
  end

  always_comb begin
    state_next       = state_reg;
    grant_data_next  = grant_data_reg;
    is_write_next    = is_write_reg;
    last_data_next   = last_data_reg;
    address_next     = address_reg;
    read_next        = read_reg;
    write_next       = write_reg;
    writedata_next   = writedata_reg;
    byteenable_next  = byteenable_reg;
    i_rdata_next     = i_rdata_reg;
    d_rdata_next     = d_rdata_reg;
    i_valid_next     = 1'b0;
    d_valid_next     = 1'b0;
    wait_cnt_next    = wait_cnt_reg;
    timeout_err_next = timeout_err_reg;

    case (state_reg)
      IDLE: begin
        if (arb.i_req || d_any) begin
          grant_data_next = pick_data;
          last_data_next  = pick_data;
          wait_cnt_next   = 16'd0;
          state_next      = REQ;
          if (pick_data) begin
            // A simultaneous read and write request is issued as a write.
            is_write_next   = arb.d_write;
            read_next       = ~arb.d_write;
            write_next      = arb.d_write;
            address_next    = arb.d_addr;
            writedata_next  = arb.d_wdata;
            byteenable_next = arb.d_byteenable;
          end else begin
            is_write_next   = 1'b0;
            read_next       = 1'b1;
            write_next      = 1'b0;
            address_next    = arb.i_addr;
            byteenable_next = 4'hF;
          end
        end
      end
      REQ: begin
        if (arb.waitrequest) begin
          if (wait_cnt_reg != 16'hFFFF) begin
            wait_cnt_next = wait_cnt_reg + 16'd1;
          end
          if ((TIMEOUT != 0) && ({16'd0, wait_cnt_next} >= TIMEOUT)) begin
            timeout_err_next = 1'b1;
          end
        end else begin
          read_next  = 1'b0;
          write_next = 1'b0;
          if (is_write_reg) begin
            // Only the data port ever writes, so its completion is signalled directly.
            d_valid_next = 1'b1;
            state_next   = DONE;
          end else begin
            state_next = RESP;
          end
        end
      end
      RESP: begin
        if (grant_data_reg) begin
          d_rdata_next = arb.readdata;
          d_valid_next = 1'b1;
        end else begin
          i_rdata_next = arb.readdata;
          i_valid_next = 1'b1;
        end
        state_next = DONE;
      end
      DONE: begin
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  assign arb.address     = address_reg;
  assign arb.read        = read_reg;
  assign arb.write       = write_reg;
  assign arb.writedata   = writedata_reg;
  assign arb.byteenable  = byteenable_reg;
  assign arb.i_rdata     = i_rdata_reg;
  assign arb.d_rdata     = d_rdata_reg;
  assign arb.i_valid     = i_valid_reg;
  assign arb.d_valid     = d_valid_reg;
  assign arb.busy        = (state_reg != IDLE);
  assign arb.timeout_err = timeout_err_reg;

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Self-checking bench: directed scenarios plus random traffic against a queue-based model,
// with a bus device model, and a second instance exercising round-robin arbitration.
module tb_mem_bus_arbiter;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset;
  logic reset_b;
  int   cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_cmp = 0;
  int n_bad = 0;

  mem_bus_arbiter_if ifa ();
  mem_bus_arbiter_if ifb ();

  mem_bus_arbiter #(.DATA_PRIORITY(1'b1), .TIMEOUT(4)) dut_a (
    .clk(clk), .reset(reset), .arb(ifa)
  );
  mem_bus_arbiter #(.DATA_PRIORITY(1'b0), .TIMEOUT(0)) dut_b (
    .clk(clk), .reset(reset_b), .arb(ifb)
  );

  typedef struct {
    logic        wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  be;
  } dbus_t;

  logic [31:0] exp_ibus[$];
  dbus_t       exp_dbus[$];
  logic [31:0] exp_irdata[$];
  logic [31:0] exp_drdata[$];
  logic [31:0] ram    [16];
  logic [31:0] shadow [16];
  logic [31:0] last_dread = 32'd0;
  int          force_stall = 0;
  bit          exp_timeout = 1'b0;
  bit          b_done = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %08h expected %08h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic fail(input string name);
    n_cmp++;
    n_bad++;
    $display("FAIL %s: event seen, none expected (t=%0t)", name, $time);
  endtask

  function automatic logic [31:0] rom(input logic [31:0] a);
    return a ^ 32'h9BC20005;
  endfunction

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] wd,
                                        input logic [3:0] be);
    logic [31:0] r;
    r = old;
    for (int b = 0; b < 4; b++) if (be[b]) r[8*b +: 8] = wd[8*b +: 8];
    return r;
  endfunction

  task automatic do_fetch(input logic [31:0] a, input int exp_lat);
    int t0;
    int n;
    @(posedge clk); #1;
    ifa.i_req  = 1'b1;
    ifa.i_addr = a;
    exp_ibus.push_back(a);
    exp_irdata.push_back(rom(a));
    t0 = cyc;
    n  = 0;
    @(negedge clk);
    while (ifa.i_valid !== 1'b1 && n < 400) begin
      @(negedge clk);
      n++;
    end
    if (ifa.i_valid !== 1'b1) fail("fetch_no_valid");
    else if (exp_lat >= 0) check("fetch_latency", 32'(cyc - t0), 32'(exp_lat));
    ifa.i_req = 1'b0;
  endtask

  task automatic do_data(input bit rd, input bit wr, input logic [31:0] a, input logic [31:0] wd,
                         input logic [3:0] be, input int exp_lat);
    int    t0;
    int    n;
    dbus_t e;
    @(posedge clk); #1;
    ifa.d_read       = rd;
    ifa.d_write      = wr;
    ifa.d_addr       = a;
    ifa.d_wdata      = wd;
    ifa.d_byteenable = be;
    e.wr = wr; e.addr = a; e.wdata = wd; e.be = be;
    exp_dbus.push_back(e);
    if (wr) shadow[a[5:2]] = merge(shadow[a[5:2]], wd, be);
    else    last_dread = shadow[a[5:2]];
    exp_drdata.push_back(last_dread);
    t0 = cyc;
    n  = 0;
    @(negedge clk);
    while (ifa.d_valid !== 1'b1 && n < 400) begin
      @(negedge clk);
      n++;
    end
    if (ifa.d_valid !== 1'b1) fail("data_no_valid");
    else if (exp_lat >= 0) check("data_latency", 32'(cyc - t0), 32'(exp_lat));
    ifa.d_read  = 1'b0;
    ifa.d_write = 1'b0;
  endtask

  // Bus device model for instance A: stalls, memory, one-cycle read return, field checks.
  initial begin
    bit          in_txn;
    bit          rd_pending;
    logic [31:0] rd_val;
    int          stall_left;
    int          stall_cnt;
    logic [31:0] r_addr, r_wdata;
    logic [3:0]  r_be;
    logic [1:0]  r_rw;
    dbus_t       e;
    in_txn = 0; rd_pending = 0; rd_val = 0; stall_left = 0; stall_cnt = 0;
    ifa.waitrequest = 1'b0;
    ifa.readdata    = 32'd0;
    forever begin
      @(negedge clk);
      check("timeout_err", {31'd0, ifa.timeout_err}, {31'd0, exp_timeout});
      ifa.readdata = rd_pending ? rd_val : $urandom;
      rd_pending = 0;
      if (reset) begin
        in_txn = 0;
        exp_timeout = 0;
        ifa.waitrequest = 1'($urandom_range(0, 1));
      end else if (ifa.read || ifa.write) begin
        if (!in_txn) begin
          in_txn = 1; stall_cnt = 0;
          r_addr = ifa.address; r_wdata = ifa.writedata; r_be = ifa.byteenable;
          r_rw = {ifa.read, ifa.write};
          stall_left = (force_stall >= 0) ? force_stall :
                       (($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 3)) : 0);
          check("rw_exclusive", {31'd0, ifa.read & ifa.write}, 32'd0);
          if (ifa.address[31:28] == 4'hB) begin
            if (exp_ibus.size() == 0) fail("unexpected_fetch_bus_op");
            else begin
              check("fetch_addr", ifa.address, exp_ibus.pop_front());
              check("fetch_be", {28'd0, ifa.byteenable}, 32'hF);
              check("fetch_read", {31'd0, ifa.read}, 32'd1);
            end
          end else if (exp_dbus.size() == 0) begin
            fail("unexpected_data_bus_op");
          end else begin
            e = exp_dbus.pop_front();
            check("data_write", {31'd0, ifa.write}, {31'd0, e.wr});
            check("data_read", {31'd0, ifa.read}, {31'd0, ~e.wr});
            check("data_addr", ifa.address, e.addr);
            check("data_be", {28'd0, ifa.byteenable}, {28'd0, e.be});
            if (e.wr) check("data_wdata", ifa.writedata, e.wdata);
          end
        end else begin
          check("hold_addr", ifa.address, r_addr);
          check("hold_wdata", ifa.writedata, r_wdata);
          check("hold_be", {28'd0, ifa.byteenable}, {28'd0, r_be});
          check("hold_strobe", {30'd0, ifa.read, ifa.write}, {30'd0, r_rw});
        end
        if (stall_left > 0) begin
          ifa.waitrequest = 1'b1;
          stall_left--;
          stall_cnt++;
          if (stall_cnt >= 4) exp_timeout = 1;
        end else begin
          ifa.waitrequest = 1'b0;
          in_txn = 0;
          if (r_rw[0]) ram[r_addr[5:2]] = merge(ram[r_addr[5:2]], r_wdata, r_be);
          else begin
            rd_pending = 1;
            rd_val = (r_addr[31:28] == 4'hB) ? rom(r_addr) : ram[r_addr[5:2]];
          end
        end
      end else begin
        if (in_txn) fail("strobe_dropped_early");
        in_txn = 0;
        ifa.waitrequest = 1'($urandom_range(0, 1));
      end
    end
  end

  // Completion monitor for instance A: every valid pulse pops and checks one expectation.
  initial begin
    forever begin
      @(negedge clk);
      if (ifa.i_valid === 1'b1) begin
        if (exp_irdata.size() == 0) fail("unexpected_i_valid");
        else check("i_rdata", ifa.i_rdata, exp_irdata.pop_front());
      end
      if (ifa.d_valid === 1'b1) begin
        if (exp_drdata.size() == 0) fail("unexpected_d_valid");
        else check("d_rdata", ifa.d_rdata, exp_drdata.pop_front());
      end
    end
  end

  // Instance B: round-robin grants against a pending-set model.
  initial begin
    bit pi, pd, last_d, exp_d;
    int n;
    int pat;
    reset_b = 1'b1;
    ifb.i_req = 0; ifb.d_read = 0; ifb.d_write = 0;
    ifb.i_addr = 32'hBFC00000; ifb.d_addr = 32'h2000; ifb.d_wdata = 0; ifb.d_byteenable = 4'hF;
    ifb.waitrequest = 0; ifb.readdata = 32'h0;
    repeat (3) @(posedge clk);
    #1 reset_b = 1'b0;
    last_d = 1; pi = 0; pd = 0;
    for (int r = 0; r < 16; r++) begin
      pat = (r < 6) ? 0 : int'($urandom_range(0, 2));
      @(posedge clk); #1;
      if (pat != 2) pi = 1;
      if (pat != 1) pd = 1;
      ifb.i_req = pi; ifb.d_read = pd;
      exp_d = pd && (!pi || !last_d);
      last_d = exp_d;
      n = 0;
      @(negedge clk);
      while (!(ifb.i_valid === 1'b1 || ifb.d_valid === 1'b1) && n < 20) begin
        @(negedge clk);
        n++;
      end
      check("rr_grant_data", {31'd0, ifb.d_valid}, {31'd0, exp_d});
      check("rr_grant_fetch", {31'd0, ifb.i_valid}, {31'd0, ~exp_d});
      if (ifb.d_valid === 1'b1) pd = 0;
      if (ifb.i_valid === 1'b1) pi = 0;
      ifb.i_req = pi; ifb.d_read = pd;
    end
    b_done = 1'b1;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int n;
    reset = 1'b1;
    ifa.i_req = 0; ifa.i_addr = 0; ifa.d_read = 0; ifa.d_write = 0;
    ifa.d_addr = 0; ifa.d_wdata = 0; ifa.d_byteenable = 0;
    for (int k = 0; k < 16; k++) begin
      ram[k]    = 32'h01010101 * k;
      shadow[k] = 32'h01010101 * k;
    end
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    check("rst_read", {31'd0, ifa.read}, 32'd0);
    check("rst_write", {31'd0, ifa.write}, 32'd0);
    check("rst_i_valid", {31'd0, ifa.i_valid}, 32'd0);
    check("rst_d_valid", {31'd0, ifa.d_valid}, 32'd0);
    check("rst_i_rdata", ifa.i_rdata, 32'd0);
    check("rst_d_rdata", ifa.d_rdata, 32'd0);
    check("rst_address", ifa.address, 32'd0);
    check("rst_writedata", ifa.writedata, 32'd0);
    check("rst_byteenable", {28'd0, ifa.byteenable}, 32'd0);
    check("rst_busy", {31'd0, ifa.busy}, 32'd0);

    force_stall = 0;
    do_fetch(32'hBFC00000, 3);
    force_stall = 3;
    do_data(1'b0, 1'b1, 32'h1000, 32'hDEADBEEF, 4'b0011, 5);
    force_stall = 0;
    do_data(1'b1, 1'b0, 32'h1000, 32'h0, 4'hF, 3);
    fork
      do_data(1'b1, 1'b0, 32'h1004, 32'h0, 4'hF, 3);
      do_fetch(32'hBFC00004, 7);
    join
    do_data(1'b1, 1'b1, 32'h1008, 32'h12345678, 4'hF, 2);
    do_data(1'b1, 1'b0, 32'h1008, 32'h0, 4'hF, 3);

    // Reset while the fetch is stalled in the request phase.
    force_stall = 100;
    @(posedge clk); #1;
    ifa.i_req = 1'b1; ifa.i_addr = 32'hBFC00008;
    exp_ibus.push_back(32'hBFC00008);
    repeat (3) @(posedge clk);
    #1 reset = 1'b1;
    ifa.i_req = 1'b0;
    exp_ibus.delete(); exp_irdata.delete(); exp_dbus.delete(); exp_drdata.delete();
    last_dread = 32'd0;
    force_stall = 0;
    @(posedge clk); #1 reset = 1'b0;
    @(negedge clk);
    check("midrst_read", {31'd0, ifa.read}, 32'd0);
    check("midrst_busy", {31'd0, ifa.busy}, 32'd0);
    check("midrst_i_valid", {31'd0, ifa.i_valid}, 32'd0);
    check("midrst_i_rdata", ifa.i_rdata, 32'd0);
    repeat (3) @(negedge clk);
    do_fetch(32'hBFC0000C, 3);

    force_stall = 6;
    do_fetch(32'hBFC00010, 9);
    @(negedge clk);
    check("timeout_sticky", {31'd0, ifa.timeout_err}, 32'd1);

    force_stall = -1;
    fork
      repeat (40) begin
        repeat ($urandom_range(0, 3)) @(posedge clk);
        do_fetch(32'hBFC00000 + (32'($urandom_range(0, 255)) << 2), -1);
      end
      repeat (40) begin
        int kind;
        repeat ($urandom_range(0, 3)) @(posedge clk);
        kind = int'($urandom_range(0, 2));
        do_data(kind != 1, kind != 0, 32'h1000 + (32'($urandom_range(0, 15)) << 2),
                $urandom, 4'($urandom_range(1, 15)), -1);
      end
    join

    repeat (5) @(negedge clk);
    n = 0;
    while (!b_done && n < 2000) begin
      @(negedge clk);
      n++;
    end
    check("rr_done", {31'd0, b_done}, 32'd1);
    check("leftover_fetch", 32'(exp_irdata.size()), 32'd0);
    check("leftover_data", 32'(exp_drdata.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
